logic_unit: RTL and testbench

LOGIC_UNIT -- requirements
Module: logic_unit

---
 rtl/logic_unit_pkg.sv | 33 +++
 rtl/logic_unit_result_fifo.sv | 82 ++++++++
 rtl/logic_unit.sv | 69 ++++++
 tb/tb_logic_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared operation encodings for the logic unit and the processor ALU.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Evaluated at full 64-bit width; callers truncate to their operand width.
  function automatic logic [63:0] apply_op(input op_e op, input logic [63:0] a,
                                           input logic [63:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      OP_NOT:  return ~a;
      OP_PASS: return a;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/logic_unit_result_fifo.sv
// Result buffer: DEPTH-entry FIFO with a registered head output that holds
// its last value when empty, and full-with-pop pass-through on in_ready.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     pop_req,
  output logic                     valid,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;
  logic             do_push;
  logic             do_pop;

  assign in_ready = !rst && ((count < CW'(DEPTH)) || pop_req);
  assign do_push  = push && in_ready;
  assign do_pop   = valid && pop_req;

  // Next pointer/count and the value the head register must show after this edge.
  always_comb begin
    rd_next    = do_pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next = count;
    head_next  = data_out;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    if (count_next != CW'(0)) begin
      if (!valid) begin
        head_next = data_in;
      end else if (do_pop) begin
        // The new head may be the entry being written on this same edge.
        head_next = (do_push && (rd_next == wr_ptr)) ? data_in : mem[rd_next];
      end else begin
        head_next = data_out;
      end
    end else begin
      head_next = data_out;
    end
  end

  // Pointer, occupancy and registered head state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
      data_out <= '0;
    end else begin
      rd_ptr   <= rd_next;
      wr_ptr   <= do_push ? wr_ptr + PW'(1) : wr_ptr;
      count    <= count_next;
      valid    <= (count_next != CW'(0));
      data_out <= head_next;
    end
  end

  // Storage array; do_push is already blocked during reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: rtl/logic_unit.sv
// Bitwise logic unit with a buffered, in-order result stream.
// Optional LOGIC_UNIT_FLAGS_EN adds per-result Out_Zero / Out_Parity outputs.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic [OP_W-1:0]        Op,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [WIDTH-1:0]       Resultado,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic                   Out_Zero,
  output logic                   Out_Parity,
`endif
  output logic [$clog2(DEPTH):0] Count
);

  logic [WIDTH-1:0] result;

  assign result = WIDTH'(apply_op(op_e'(Op), 64'(A), 64'(B)));

`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int ENTRY_W = WIDTH + 2;

  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] entry_out;

  assign entry_in   = {(result == '0), parity_of(result), result};
  assign Out_Zero   = entry_out[WIDTH+1];
  assign Out_Parity = entry_out[WIDTH];
  assign Resultado  = entry_out[WIDTH-1:0];
`else
  localparam int ENTRY_W = WIDTH;

  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] entry_out;

  assign entry_in  = result;
  assign Resultado = entry_out;
`endif

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (Clock),
    .rst      (Reset),
    .push     (In_Valid),
    .in_ready (In_Ready),
    .data_in  (entry_in),
    .pop_req  (Out_Ready),
    .valid    (Out_Valid),
    .data_out (entry_out),
    .count    (Count)
  );

endmodule

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit: truth table, backpressure, full push/pop,
// reset mid-stream, empty pop, 16-bit width, and flags when enabled.
module tb_logic_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        In_Valid;
  logic        Out_Ready;
  logic [2:0]  Op;
  logic [7:0]  A8, B8;
  logic [15:0] A16, B16;

  logic        in_ready8, out_valid8;
  logic [7:0]  res8;
  logic [1:0]  count8;
  logic        in_ready16, out_valid16;
  logic [15:0] res16;
  logic [1:0]  count16;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic        zero8, par8, zero16, par16;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] tt_exp [8];

  always #5 Clock = ~Clock;

  logic_unit #(.WIDTH(8), .DEPTH(2)) u8 (
    .Clock     (Clock),
    .Reset     (Reset),
    .In_Valid  (In_Valid),
    .In_Ready  (in_ready8),
    .Op        (Op),
    .A         (A8),
    .B         (B8),
    .Out_Valid (out_valid8),
    .Out_Ready (Out_Ready),
    .Resultado (res8),
`ifdef LOGIC_UNIT_FLAGS_EN
    .Out_Zero  (zero8),
    .Out_Parity(par8),
`endif
    .Count     (count8)
  );

  logic_unit #(.WIDTH(16), .DEPTH(2)) u16 (
    .Clock     (Clock),
    .Reset     (Reset),
    .In_Valid  (In_Valid),
    .In_Ready  (in_ready16),
    .Op        (Op),
    .A         (A16),
    .B         (B16),
    .Out_Valid (out_valid16),
    .Out_Ready (Out_Ready),
    .Resultado (res16),
`ifdef LOGIC_UNIT_FLAGS_EN
    .Out_Zero  (zero16),
    .Out_Parity(par16),
`endif
    .Count     (count16)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    In_Valid = v;
    Op       = op;
    A8       = a;
    B8       = b;
  endtask

  initial begin
    tt_exp[0] = 8'hC0; tt_exp[1] = 8'hFC; tt_exp[2] = 8'h3C; tt_exp[3] = 8'h3F;
    tt_exp[4] = 8'h03; tt_exp[5] = 8'hC3; tt_exp[6] = 8'h0F; tt_exp[7] = 8'hF0;

    Reset = 1'b1; Out_Ready = 1'b0;
    drive(1'b1, 3'b111, 8'h00, 8'h00);
    A16 = 16'h0000; B16 = 16'h00FF;
    tick();
    tick();
    check("in_ready_in_reset", 64'(in_ready8), 64'd0);
    Reset = 1'b0; In_Valid = 1'b0;
    #1;
    check("reset_count", 64'(count8), 64'd0);
    check("reset_out_valid", 64'(out_valid8), 64'd0);
    check("reset_result", 64'(res8), 64'h00);

    // Truth table with the consumer always ready.
    Out_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'hF0, 8'hCC);
      tick();
      check($sformatf("tt_valid_op%0d", i), 64'(out_valid8), 64'd1);
      check($sformatf("tt_result_op%0d", i), 64'(res8), 64'(tt_exp[i]));
      if (i == 4) check("w16_nor", 64'(res16), 64'hFF00);
    end
    In_Valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid8), 64'd0);
    check("hold_after_drain", 64'(res8), 64'hF0);
    tick();
    check("empty_pop_count", 64'(count8), 64'd0);
    check("empty_pop_hold", 64'(res8), 64'hF0);

    // Backpressure: third set must wait for the first pop.
    Out_Ready = 1'b0;
    drive(1'b1, 3'b111, 8'h11, 8'hFF); tick();
    check("bp_head_first", 64'(res8), 64'h11);
    drive(1'b1, 3'b111, 8'h22, 8'hFF); tick();
    check("bp_count_full", 64'(count8), 64'd2);
    check("bp_in_ready_low", 64'(in_ready8), 64'd0);
    drive(1'b1, 3'b111, 8'h33, 8'hFF); tick();
    check("bp_count_stays", 64'(count8), 64'd2);
    check("bp_head_stable", 64'(res8), 64'h11);
    Out_Ready = 1'b1;
    #1;
    check("bp_in_ready_passthru", 64'(in_ready8), 64'd1);
    tick();
    check("bp_pop1_head", 64'(res8), 64'h22);
    check("bp_pop1_count", 64'(count8), 64'd2);
    In_Valid = 1'b0;
    tick();
    check("bp_pop2_head", 64'(res8), 64'h33);
    check("bp_pop2_count", 64'(count8), 64'd1);
    tick();
    check("bp_empty", 64'(count8), 64'd0);

    // Full with simultaneous push and pop for four cycles.
    Out_Ready = 1'b0;
    drive(1'b1, 3'b111, 8'h01, 8'h00); tick();
    drive(1'b1, 3'b111, 8'h02, 8'h00); tick();
    Out_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b111, 8'(3 + i), 8'h00);
      tick();
      check($sformatf("full_pp_count%0d", i), 64'(count8), 64'd2);
      check($sformatf("full_pp_head%0d", i), 64'(res8), 64'(2 + i));
    end
    In_Valid = 1'b0;
    tick();
    check("full_pp_tail", 64'(res8), 64'h06);
    check("full_pp_tail_count", 64'(count8), 64'd1);
    tick();
    check("full_pp_empty", 64'(out_valid8), 64'd0);

    // Reset mid-stream discards results and ignores the push in that cycle.
    Out_Ready = 1'b0;
    drive(1'b1, 3'b111, 8'hAA, 8'h00); tick();
    drive(1'b1, 3'b111, 8'hBB, 8'h00); tick();
    check("mid_count_before", 64'(count8), 64'd2);
    Reset = 1'b1; Out_Ready = 1'b1;
    drive(1'b1, 3'b111, 8'hCC, 8'h00);
    tick();
    Reset = 1'b0; In_Valid = 1'b0;
    check("mid_reset_count", 64'(count8), 64'd0);
    check("mid_reset_valid", 64'(out_valid8), 64'd0);
    check("mid_reset_result", 64'(res8), 64'h00);
    Out_Ready = 1'b0;
    drive(1'b1, 3'b111, 8'h5A, 8'h00); tick();
    In_Valid = 1'b0;
    check("post_reset_valid", 64'(out_valid8), 64'd1);
    check("post_reset_result", 64'(res8), 64'h5A);
    check("post_reset_count", 64'(count8), 64'd1);

`ifdef LOGIC_UNIT_FLAGS_EN
    Out_Ready = 1'b1;
    tick();
    drive(1'b1, 3'b000, 8'hAA, 8'h55); tick();
    check("flag_and_result", 64'(res8), 64'h00);
    check("flag_and_zero", 64'(zero8), 64'd1);
    check("flag_and_parity", 64'(par8), 64'd0);
    drive(1'b1, 3'b010, 8'h01, 8'h00); tick();
    In_Valid = 1'b0;
    check("flag_xor_zero", 64'(zero8), 64'd0);
    check("flag_xor_parity", 64'(par8), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
